// File: rtl/family_selector.sv
// Scores every member of a family of closed routes against an external
// synchronous distance ROM and returns the cheapest member as the next parent.
module family_selector #(
    parameter int N_MEMBERS = 5,
    parameter int N_STOPS   = 15,
    parameter int IDX_W     = 5,
    parameter int DIST_W    = 8,
    parameter int COST_W    = 12
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [N_MEMBERS*N_STOPS*IDX_W-1:0]   family,
    output logic [IDX_W-1:0]                     dist_a,
    output logic [IDX_W-1:0]                     dist_b,
    input  logic [DIST_W-1:0]                    dist_data,
    output logic                                 busy,
    output logic [N_STOPS*IDX_W-1:0]             best,
    output logic [COST_W-1:0]                    best_cost,
    output logic                                 done
);

    localparam int ROUTE_W = N_STOPS * IDX_W;
    localparam int FAM_W   = N_MEMBERS * ROUTE_W;
    localparam int LEG_W   = $clog2(N_STOPS + 1);
    localparam int MEM_W   = (N_MEMBERS > 1) ? $clog2(N_MEMBERS) : 1;

    localparam logic [LEG_W-1:0] LAST_LEG    = LEG_W'(N_STOPS);
    localparam logic [LEG_W-1:0] LAST_ISSUE  = LEG_W'(N_STOPS - 1);
    localparam logic [MEM_W-1:0] LAST_MEMBER = MEM_W'(N_MEMBERS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        CMP,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [FAM_W-1:0]       fam_q, fam_d;
    logic [MEM_W-1:0]       member_q, member_d;
    logic [LEG_W-1:0]       leg_q, leg_d;
    logic [COST_W-1:0]      acc_q, acc_d;
    logic [COST_W-1:0]      min_q, min_d;
    logic [MEM_W-1:0]       best_idx_q, best_idx_d;
    logic [ROUTE_W-1:0]     best_q, best_d;
    logic [COST_W-1:0]      best_cost_q, best_cost_d;
    logic [IDX_W-1:0]       dist_a_q, dist_a_d;
    logic [IDX_W-1:0]       dist_b_q, dist_b_d;

    logic                   issue;
    logic [ROUTE_W-1:0]     issue_route;
    logic [LEG_W-1:0]       issue_leg;
    logic [LEG_W-1:0]       issue_next;
    logic                   acc_lt_min;

    function automatic logic [IDX_W-1:0] stop_at(input logic [ROUTE_W-1:0] route,
                                                 input logic [LEG_W-1:0]   k);
        return route[k*IDX_W +: IDX_W];
    endfunction

    function automatic logic [ROUTE_W-1:0] route_at(input logic [FAM_W-1:0] fam,
                                                    input logic [MEM_W-1:0] m);
        return fam[m*ROUTE_W +: ROUTE_W];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            fam_q       <= '0;
            member_q    <= '0;
            leg_q       <= '0;
            acc_q       <= '0;
            min_q       <= '0;
            best_idx_q  <= '0;
            best_q      <= '0;
            best_cost_q <= '0;
            dist_a_q    <= '0;
            dist_b_q    <= '0;
        end else begin
            state_q     <= state_d;
            fam_q       <= fam_d;
            member_q    <= member_d;
            leg_q       <= leg_d;
            acc_q       <= acc_d;
            min_q       <= min_d;
            best_idx_q  <= best_idx_d;
            best_q      <= best_d;
            best_cost_q <= best_cost_d;
            dist_a_q    <= dist_a_d;
            dist_b_q    <= dist_b_d;
        end
    end

    // The ROM address registers are loaded with the leg that the next cycle
    // owns, so the response arrives while the following leg is in progress.
    always_comb begin
        state_d     = state_q;
        fam_d       = fam_q;
        member_d    = member_q;
        leg_d       = leg_q;
        acc_d       = acc_q;
        min_d       = min_q;
        best_idx_d  = best_idx_q;
        best_d      = best_q;
        best_cost_d = best_cost_q;
        issue       = 1'b0;
        issue_route = '0;
        issue_leg   = '0;
        acc_lt_min  = (acc_q < min_q);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    fam_d       = family;
                    member_d    = '0;
                    leg_d       = '0;
                    acc_d       = '0;
                    min_d       = '1;
                    best_idx_d  = '0;
                    issue       = 1'b1;
                    issue_route = route_at(family, '0);
                end
            end
            RUN: begin
                if (leg_q != '0) begin
                    acc_d = acc_q + {{(COST_W-DIST_W){1'b0}}, dist_data};
                end
                if (leg_q == LAST_LEG) begin
                    state_d = CMP;
                end else begin
                    leg_d = leg_q + 1'b1;
                    if (leg_q < LAST_ISSUE) begin
                        issue       = 1'b1;
                        issue_route = route_at(fam_q, member_q);
                        issue_leg   = leg_q + 1'b1;
                    end
                end
            end
            CMP: begin
                if (acc_lt_min) begin
                    min_d      = acc_q;
                    best_idx_d = member_q;
                end
                if (member_q < LAST_MEMBER) begin
                    state_d     = RUN;
                    member_d    = member_q + 1'b1;
                    acc_d       = '0;
                    leg_d       = '0;
                    issue       = 1'b1;
                    issue_route = route_at(fam_q, member_q + 1'b1);
                end else begin
                    state_d     = DONE;
                    best_d      = route_at(fam_q, acc_lt_min ? member_q : best_idx_q);
                    best_cost_d = acc_lt_min ? acc_q : min_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        issue_next = (issue_leg == LAST_ISSUE) ? '0 : issue_leg + 1'b1;
        dist_a_d   = issue ? stop_at(issue_route, issue_leg)  : dist_a_q;
        dist_b_d   = issue ? stop_at(issue_route, issue_next) : dist_b_q;
    end

    assign dist_a    = dist_a_q;
    assign dist_b    = dist_b_q;
    assign busy      = (state_q == RUN) || (state_q == CMP);
    assign done      = (state_q == DONE);
    assign best      = best_q;
    assign best_cost = best_cost_q;

endmodule

// File: tb/tb_family_selector.sv
// Randomized bench for family_selector: a behavioural ROM plus a route-cost
// reference model decide the expected winner, cost and latency of each run.
module tb_family_selector;

    localparam int N_MEMBERS = 5;
    localparam int N_STOPS   = 15;
    localparam int IDX_W     = 5;
    localparam int DIST_W    = 8;
    localparam int COST_W    = 12;
    localparam int ROUTE_W   = N_STOPS * IDX_W;
    localparam int FAM_W     = N_MEMBERS * ROUTE_W;
    localparam int LATENCY   = 86;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [FAM_W-1:0]     family;
    logic [IDX_W-1:0]     dist_a;
    logic [IDX_W-1:0]     dist_b;
    logic [DIST_W-1:0]    dist_data;
    logic                 busy;
    logic [ROUTE_W-1:0]   best;
    logic [COST_W-1:0]    best_cost;
    logic                 done;

    int                   checks = 0;
    int                   failures = 0;
    int                   rom_mode = 0;
    int                   done_cnt = 0;
    logic [7:0]           rom_tbl [32][32];

    family_selector dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .family    (family),
        .dist_a    (dist_a),
        .dist_b    (dist_b),
        .dist_data (dist_data),
        .busy      (busy),
        .best      (best),
        .best_cost (best_cost),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Mode 0: |a-b|, mode 1: constant 255, mode 2: random table.
    function automatic int romVal(input int a, input int b);
        if (rom_mode == 0) return (a > b) ? a - b : b - a;
        if (rom_mode == 1) return 255;
        return int'(rom_tbl[a][b]);
    endfunction

    always @(posedge clk) dist_data <= DIST_W'(romVal(int'(dist_a), int'(dist_b)));

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    function automatic logic [ROUTE_W-1:0] getRoute(input logic [FAM_W-1:0] fam, input int m);
        return fam[m*ROUTE_W +: ROUTE_W];
    endfunction

    function automatic int getStop(input logic [ROUTE_W-1:0] r, input int k);
        return int'(r[k*IDX_W +: IDX_W]);
    endfunction

    function automatic int routeCost(input logic [ROUTE_W-1:0] r);
        int sum = 0;
        for (int k = 0; k < N_STOPS; k++)
            sum += romVal(getStop(r, k), getStop(r, (k + 1) % N_STOPS));
        return sum;
    endfunction

    function automatic int bestIdx(input logic [FAM_W-1:0] fam);
        int bi = 0;
        int bc = routeCost(getRoute(fam, 0));
        for (int m = 1; m < N_MEMBERS; m++) begin
            if (routeCost(getRoute(fam, m)) < bc) begin
                bc = routeCost(getRoute(fam, m));
                bi = m;
            end
        end
        return bi;
    endfunction

    function automatic logic [ROUTE_W-1:0] permRoute();
        int p [N_STOPS];
        logic [ROUTE_W-1:0] r;
        for (int k = 0; k < N_STOPS; k++) p[k] = k;
        for (int k = N_STOPS - 1; k > 0; k--) begin
            int j = int'($urandom_range(k, 0));
            int t = p[k];
            p[k] = p[j];
            p[j] = t;
        end
        for (int k = 0; k < N_STOPS; k++) r[k*IDX_W +: IDX_W] = IDX_W'(p[k]);
        return r;
    endfunction

    function automatic logic [FAM_W-1:0] randomFamily();
        logic [FAM_W-1:0] f;
        for (int i = 0; i < FAM_W; i++) f[i] = 1'($urandom);
        return f;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; start is sampled at the next rising edge.
    task automatic applyStimulus(input logic [FAM_W-1:0] fam);
        family = fam;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic waitDone(input int first, output int c);
        c = first;
        while (done !== 1'b1 && c < 300) begin
            @(negedge clk);
            c++;
        end
        if (done !== 1'b1) checkOutput("done_timeout", 0, 1);
    endtask

    task automatic checkResult(input string tag, input logic [FAM_W-1:0] fam, input int lat);
        logic [ROUTE_W-1:0] exp_best;
        exp_best = getRoute(fam, bestIdx(fam));
        checkOutput({tag, "_latency"}, lat, LATENCY);
        checkOutput({tag, "_best"}, best, exp_best);
        checkOutput({tag, "_cost"}, best_cost, routeCost(exp_best));
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, done, 0);
        checkOutput({tag, "_hold"}, best, exp_best);
    endtask

    task automatic runCheck(input string tag, input logic [FAM_W-1:0] fam);
        int lat;
        applyStimulus(fam);
        waitDone(1, lat);
        checkResult(tag, fam, lat);
    endtask

    initial begin
        logic [FAM_W-1:0]   fam;
        logic [FAM_W-1:0]   fam_b;
        logic [ROUTE_W-1:0] r;
        logic [ROUTE_W-1:0] ident;
        int                 lat;
        int                 snap;

        for (int a = 0; a < 32; a++)
            for (int b = 0; b < 32; b++)
                rom_tbl[a][b] = 8'($urandom);

        rst    = 1'b1;
        start  = 1'b0;
        family = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_best", best, 0);
        checkOutput("reset_cost", best_cost, 0);
        checkOutput("reset_dist_a", dist_a, 0);
        checkOutput("reset_dist_b", dist_b, 0);

        // Ordered route wins under |a-b|; shuffles are redrawn until strictly worse.
        rom_mode = 0;
        for (int k = 0; k < N_STOPS; k++) ident[k*IDX_W +: IDX_W] = IDX_W'(k);
        for (int m = 0; m < N_MEMBERS; m++) begin
            r = ident;
            if (m != 2) begin
                r = permRoute();
                while (routeCost(r) <= 28) r = permRoute();
            end
            fam[m*ROUTE_W +: ROUTE_W] = r;
        end
        applyStimulus(fam);
        waitDone(1, lat);
        checkOutput("ordered_best_is_member2", best, ident);
        checkOutput("ordered_cost_28", best_cost, 28);
        checkResult("ordered", fam, lat);

        rom_mode = 2;
        r = permRoute();
        for (int m = 0; m < N_MEMBERS; m++) fam[m*ROUTE_W +: ROUTE_W] = r;
        applyStimulus(fam);
        waitDone(1, lat);
        checkOutput("tie_best_member0", best, r);
        checkResult("tie", fam, lat);

        rom_mode = 1;
        fam = randomFamily();
        applyStimulus(fam);
        waitDone(1, lat);
        checkOutput("max_cost_3825", best_cost, 3825);
        checkOutput("max_best_member0", best, getRoute(fam, 0));
        checkResult("max", fam, lat);

        // Abort a run with reset at cycle 40, then confirm no done appears.
        rom_mode = 2;
        fam = randomFamily();
        applyStimulus(fam);
        repeat (39) @(negedge clk);
        checkOutput("abort_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_best", best, 0);
        checkOutput("abort_cost", best_cost, 0);
        @(negedge clk);
        rst  = 1'b0;
        snap = done_cnt;
        repeat (120) @(negedge clk);
        checkOutput("abort_no_done", done_cnt - snap, 0);
        runCheck("after_abort", fam);

        // A second start mid-run with a different family must be ignored.
        fam   = randomFamily();
        fam_b = randomFamily();
        snap  = done_cnt;
        applyStimulus(fam);
        repeat (9) @(negedge clk);
        applyStimulus(fam_b);
        waitDone(11, lat);
        checkResult("ignore_start", fam, lat);
        repeat (100) @(negedge clk);
        checkOutput("ignore_single_done", done_cnt - snap, 1);

        // ROM address stream for member 0, including the closing leg.
        fam = randomFamily();
        r   = getRoute(fam, 0);
        applyStimulus(fam);
        for (int k = 0; k < N_STOPS; k++) begin
            checkOutput($sformatf("seq_a%0d", k), dist_a, getStop(r, k));
            checkOutput($sformatf("seq_b%0d", k), dist_b, getStop(r, (k + 1) % N_STOPS));
            @(negedge clk);
        end
        checkOutput("seq_hold_a", dist_a, getStop(r, N_STOPS - 1));
        checkOutput("seq_hold_b", dist_b, getStop(r, 0));
        waitDone(16, lat);
        checkResult("seq", fam, lat);

        // Start held high: the next run starts in the IDLE cycle after DONE.
        fam    = randomFamily();
        family = fam;
        start  = 1'b1;
        @(negedge clk);
        waitDone(1, lat);
        checkOutput("held_latency1", lat, LATENCY);
        @(negedge clk);
        checkOutput("held_idle_busy", busy, 0);
        @(negedge clk);
        start = 1'b0;
        checkOutput("held_rerun_busy", busy, 1);
        waitDone(1, lat);
        checkResult("held_rerun", fam, lat);

        for (int i = 0; i < 4; i++) runCheck($sformatf("rand%0d", i), randomFamily());

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
